// File: rtl/cdp_rdma_eg_rsp_buf.sv
// CDP RDMA egress response buffer: DEPTH-entry FIFO for read-response beats
// plus an outstanding-request counter that gates the ingress request pipe.
module cdp_rdma_eg_rsp_buf #(
    parameter int DW    = 514,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             dma_rd_rsp_vld,
    output logic             dma_rd_rsp_rdy,
    input  logic [DW-1:0]    dma_rd_rsp_pd,
    input  logic             req_issue,
    output logic             ig_req_allow,
    output logic             rsp_out_vld,
    input  logic             rsp_out_rdy,
    output logic [DW-1:0]    rsp_out_pd,
    output logic [CNT_W-1:0] fifo_cnt,
    output logic [CNT_W-1:0] outs_cnt,
    output logic             rsp_unexp_err,
    output logic             idle
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Handshakes: a beat transfers on a rising clock edge where vld & rdy are
    // both high; the source holds vld and payload stable until that happens.
    // Both rdy/vld here come from registered counts only, never from the peer.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          push;
    logic          pop;

    assign dma_rd_rsp_rdy = (fifo_cnt != CNT_FULL);
    assign rsp_out_vld    = (fifo_cnt != '0);
    assign push           = dma_rd_rsp_vld & dma_rd_rsp_rdy;
    assign pop            = rsp_out_vld & rsp_out_rdy;
    assign rsp_out_pd     = mem[rp];
    assign ig_req_allow   = (outs_cnt != CNT_FULL);
    assign idle           = (fifo_cnt == '0) && (outs_cnt == '0);

    // Payload storage carries no reset; validity is tracked by fifo_cnt.
    always_ff @(posedge nvdla_core_clk) begin
        if (push) begin
            mem[wp] <= dma_rd_rsp_pd;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wp       <= '0;
            rp       <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - CNT_W'(1);
            end
        end
    end

    // Outstanding count saturates at DEPTH and floors at 0 so a protocol
    // violation cannot wrap the credit and re-open the ingress pipe.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            outs_cnt <= '0;
        end else if (req_issue && !pop && (outs_cnt != CNT_FULL)) begin
            outs_cnt <= outs_cnt + CNT_W'(1);
        end else if (pop && !req_issue && (outs_cnt != '0)) begin
            outs_cnt <= outs_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rsp_unexp_err <= 1'b0;
        end else if (push && (outs_cnt == '0)) begin
            rsp_unexp_err <= 1'b1;
        end
    end

endmodule

// File: doc/cdp_rdma_eg_rsp_buf.md
# cdp_rdma_eg_rsp_buf

Response-side buffer for the CDP read DMA. It accepts read-response beats from the memory interface into a DEPTH-entry FIFO and presents them, in order, to the CDP RDMA egress datapath over a valid/ready handshake. It also counts outstanding read requests and returns a credit-style grant (`ig_req_allow`) to the ingress request pipe. Because of that grant, responses can never exceed buffer space. The block sits opposite the ingress read-request pipe stage, on the return path of the same DMA read interface.

## Interface
Parameters:
- `DW`, 514, response payload width (512b data + 2b mask).
- `DEPTH`, 8, FIFO entries and maximum outstanding requests; power of two, ≥2.
- `CNT_W`, clog2(DEPTH+1), width of the occupancy and outstanding counters.

Ports:
- `nvdla_core_clk`  in  1  clock.
- `nvdla_core_rstn`  in  1  reset, asynchronous, active-low.
- `dma_rd_rsp_vld`  in  1  response beat valid from memory interface.
- `dma_rd_rsp_rdy`  out  1  buffer can accept a beat.
- `dma_rd_rsp_pd`  in  DW  response payload.
- `req_issue`  in  1  one-cycle pulse per read request accepted by the ingress pipe (request vld & rdy).
- `ig_req_allow`  out  1  ingress may issue another request.
- `rsp_out_vld`  out  1  head beat valid to egress datapath.
- `rsp_out_rdy`  in  1  egress datapath accepts head beat.
- `rsp_out_pd`  out  DW  head beat payload.
- `fifo_cnt`  out  CNT_W  current occupancy.
- `outs_cnt`  out  CNT_W  outstanding requests (issued, not yet popped downstream).
- `rsp_unexp_err`  out  1  sticky flag: response arrived with `outs_cnt`==0.
- `idle`  out  1  `fifo_cnt`==0 and `outs_cnt`==0.

## Operation
- Storage: DEPTH×DW register array with write pointer `wp` and read pointer `rp`, each clog2(DEPTH) bits. Both wrap modulo DEPTH. The array is not reset.
- Push: `dma_rd_rsp_vld & dma_rd_rsp_rdy`. Writes `mem[wp]` and increments `wp`.
- Pop: `rsp_out_vld & rsp_out_rdy`. Increments `rp`.
- `dma_rd_rsp_rdy` = (`fifo_cnt` != DEPTH). It is derived from the registered count only, with no combinational path from `rsp_out_rdy`.
- `fifo_cnt`: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- `rsp_out_vld` = (`fifo_cnt` != 0). `rsp_out_pd` = `mem[rp]`, and is don't-care while `rsp_out_vld`=0.
- No bypass: a pushed beat is not visible at the output in the cycle it is written.
- Outstanding counter `outs_cnt`: +1 on `req_issue` only, −1 on pop only, unchanged when both occur.
  - Saturates at DEPTH: a `req_issue` with `outs_cnt`==DEPTH is a protocol violation and the count is held.
  - Decrement from 0 is held at 0.
- `ig_req_allow` = (`outs_cnt` < DEPTH), registered-count based. This guarantees `fifo_cnt` ≤ `outs_cnt` ≤ DEPTH in legal operation.
- `rsp_unexp_err`: set on any push while `outs_cnt`==0. It stays set until reset. The beat is still stored if `dma_rd_rsp_rdy`=1.
- Order is strictly preserved: output beat k equals input beat k.
- Payload must be held stable by the source while vld=1 and rdy=0. Once asserted, `rsp_out_vld` stays high until popped.

## Timing
- Reset values (asynchronous):
  - `wp`=`rp`=0, `fifo_cnt`=0, `outs_cnt`=0, `rsp_unexp_err`=0.
  - Hence `dma_rd_rsp_rdy`=1, `rsp_out_vld`=0, `ig_req_allow`=1, `idle`=1.
- Latency: a beat pushed in cycle N raises `rsp_out_vld` in cycle N+1 (if the FIFO was empty). Minimum push-to-pop is 1 cycle.
- Throughput: one push and one pop per cycle sustained. A full FIFO with a pop in cycle N shows `dma_rd_rsp_rdy`=1 in cycle N+1.
- Effect timing: `req_issue` in cycle N appears in `outs_cnt` / `ig_req_allow` in cycle N+1. `ig_req_allow` drops the cycle after the DEPTH-th outstanding request is issued.
- Wrap-around: `wp`/`rp` roll from DEPTH−1 to 0 with no bubble.
- Reset mid-operation: all buffered beats are discarded and all counters clear immediately. No output beat is produced after reset until a new push.

## Test plan
- Reset, then 1 `req_issue`, then 1 push of pd=0x1A5 (`rsp_out_rdy`=1) -> `rsp_out_vld` high exactly one cycle with pd=0x1A5; `outs_cnt` 0→1→0; `idle` returns to 1.
- 8 `req_issue` pulses -> `ig_req_allow`=0 the cycle after the 8th. Then 8 pushes with `rsp_out_rdy`=0 -> `fifo_cnt`=8, `dma_rd_rsp_rdy`=0; a 9th vld is held off.
- Full FIFO, `rsp_out_rdy`=1 with continuous pushes for 20 beats (incrementing pd) -> one beat out per cycle, in order, pointers wrap twice, no loss or duplication.
- Simultaneous `req_issue` and pop with `outs_cnt`=3 -> `outs_cnt` stays 3. Simultaneous push and pop with `fifo_cnt`=4 -> `fifo_cnt` stays 4.
- Push with `outs_cnt`=0 -> `rsp_unexp_err`=1 next cycle and stays 1 through later traffic. Only `nvdla_core_rstn` clears it.
- Assert reset with `fifo_cnt`=5, `outs_cnt`=7 -> immediately `rsp_out_vld`=0, `dma_rd_rsp_rdy`=1, `ig_req_allow`=1, both counts 0.
